// File: rtl/phase_freq_detector_pkg.sv
// Shared widths, FSM state encoding and small helpers for the DPLL phase/frequency detector.
package phase_freq_detector_pkg;

  localparam int unsigned N_BIT           = 16;
  localparam int unsigned TIMEOUT_DEFAULT = (1 << N_BIT) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD1 = 2'd1,
    LEAD2 = 2'd2
  } pfd_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [N_BIT-1:0] sat_inc(input logic [N_BIT-1:0] v);
    return (v == '1) ? v : v + N_BIT'(1);
  endfunction

endpackage

// File: rtl/phase_freq_detector_edge_sync.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse on each rising edge of din.
module phase_freq_detector_edge_sync
  import phase_freq_detector_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign rise_c = sync_2 & ~prev;

endmodule

// File: rtl/phase_freq_detector.sv
// Phase/frequency detector: lead/lag between f_1 and f_2 edges and f_1 period, in clk cycles.
module phase_freq_detector
  import phase_freq_detector_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_1,
  input  logic             f_2,
  output logic             first_second,
  output logic             timeout,
  output logic             ready,
  output logic [N_BIT-1:0] diff_1,
  output logic [N_BIT-1:0] diff_2,
  output logic [N_BIT-1:0] f_out
);

  localparam logic [N_BIT-1:0] TIMEOUT_W = N_BIT'(TIMEOUT);

  logic             r_1;
  logic             r_2;
  pfd_state_e       state;
  logic [N_BIT-1:0] cnt;
  logic [N_BIT-1:0] pcnt;
  logic             r_1_seen;

  phase_freq_detector_edge_sync u_sync_1 (
    .clk    (clk),
    .reset  (reset),
    .din    (f_1),
    .rise_c (r_1)
  );

  phase_freq_detector_edge_sync u_sync_2 (
    .clk    (clk),
    .reset  (reset),
    .din    (f_2),
    .rise_c (r_2)
  );

  // Lead/lag FSM; count starts at 1 on the leading edge so k-cycle spacing reads as k.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ready        <= 1'b0;
      timeout      <= 1'b0;
      first_second <= 1'b0;
      diff_1       <= '0;
      diff_2       <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (r_1 && r_2) begin
            diff_1       <= '0;
            diff_2       <= '0;
            first_second <= 1'b0;
            ready        <= 1'b1;
            timeout      <= 1'b0;
          end else if (r_1) begin
            cnt   <= N_BIT'(1);
            state <= LEAD1;
          end else if (r_2) begin
            cnt   <= N_BIT'(1);
            state <= LEAD2;
          end
        end
        LEAD1: begin
          if (r_2) begin
            diff_1       <= cnt;
            diff_2       <= '0;
            first_second <= 1'b0;
            ready        <= 1'b1;
            timeout      <= 1'b0;
            state        <= IDLE;
          end else if (cnt == TIMEOUT_W) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + N_BIT'(1);
          end
        end
        LEAD2: begin
          if (r_1) begin
            diff_2       <= cnt;
            diff_1       <= '0;
            first_second <= 1'b1;
            ready        <= 1'b1;
            timeout      <= 1'b0;
            state        <= IDLE;
          end else if (cnt == TIMEOUT_W) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + N_BIT'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // f_1 period counter; the first edge after reset only arms the measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt     <= '0;
      r_1_seen <= 1'b0;
      f_out    <= '0;
    end else if (r_1) begin
      if (r_1_seen) begin
        f_out <= pcnt;
      end
      pcnt     <= N_BIT'(1);
      r_1_seen <= 1'b1;
    end else begin
      pcnt <= sat_inc(pcnt);
    end
  end

endmodule

// File: tb/tb_phase_freq_detector.sv
// Self-checking bench for phase_freq_detector: table-driven waveforms plus hand-written corner sequences.
`timescale 1ns/100ps
module tb_phase_freq_detector;
  import phase_freq_detector_pkg::*;

  localparam int unsigned TB_TIMEOUT = 100;

  typedef struct {
    logic       fs;
    int         d1;
    int         d2;
  } exp_t;

  typedef struct {
    int   off1;
    int   off2;
    int   half;
    int   ncyc;
    logic comp_f1;
    logic fs;
    int   d1;
    int   d2;
    int   nready;
    int   fout;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             f_1;
  logic             f_2;
  logic             first_second;
  logic             timeout;
  logic             ready;
  logic [N_BIT-1:0] diff_1;
  logic [N_BIT-1:0] diff_2;
  logic [N_BIT-1:0] f_out;

  int   total = 0;
  int   bad   = 0;
  int   ready_seen = 0;
  exp_t q[$];

  int   wcyc;
  int   off1, off2, half;
  logic en1, en2, comp_f1;
  exp_t cur_exp;

  vec_t vecs[7];

  phase_freq_detector #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .f_1          (f_1),
    .f_2          (f_2),
    .first_second (first_second),
    .timeout      (timeout),
    .ready        (ready),
    .diff_1       (diff_1),
    .diff_2       (diff_2),
    .f_out        (f_out)
  );

  always #0.5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; outputs sampled on the falling edge, ready pulses scored against the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (ready) begin
      ready_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ready: got ready=1 want no pending result (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("first_second", int'(first_second), int'(e.fs));
        check("diff_1", int'(diff_1), e.d1);
        check("diff_2", int'(diff_2), e.d2);
        check("timeout_on_ready", int'(timeout), 0);
      end
    end
  endtask

  function automatic logic lvl(input int c, input int off, input int hp);
    return (c >= off) && ((((c - off) / hp) % 2) == 0);
  endfunction

  task automatic run_waves(input int n);
    logic n1, n2;
    for (int i = 0; i < n; i++) begin
      tick();
      wcyc++;
      n1 = en1 && lvl(wcyc, off1, half);
      n2 = en2 && lvl(wcyc, off2, half);
      if (comp_f1 ? (n1 && !f_1) : (n2 && !f_2)) q.push_back(cur_exp);
      f_1 = n1;
      f_2 = n2;
    end
  endtask

  task automatic run_to(input int target);
    run_waves(target - wcyc);
  endtask

  task automatic drain(input int n);
    f_1 = 1'b0;
    f_2 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_first_second"}, int'(first_second), 0);
    check({tag, "_diff_1"}, int'(diff_1), 0);
    check({tag, "_diff_2"}, int'(diff_2), 0);
    check({tag, "_f_out"}, int'(f_out), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    f_1   = 1'b0;
    f_2   = 1'b0;
    tick();
    check_zero(tag);
    reset = 1'b0;
    q.delete();
    ready_seen = 0;
    wcyc = 0;
  endtask

  initial begin
    reset = 1'b1;
    f_1   = 1'b0;
    f_2   = 1'b0;
    en1   = 1'b1;
    en2   = 1'b1;
    comp_f1 = 1'b0;
    off1 = 0; off2 = 0; half = 1; wcyc = 0;
    cur_exp = '{fs: 1'b0, d1: 0, d2: 0};

    //            off1 off2 half ncyc cf1   fs    d1   d2  nrdy fout
    vecs[0] = '{200, 220, 100, 950, 1'b0, 1'b0, 20,  0,  4, 200};
    vecs[1] = '{235, 200, 100, 950, 1'b1, 1'b1, 0,   35, 4, 200};
    vecs[2] = '{200, 200, 100, 950, 1'b0, 1'b0, 0,   0,  4, 200};
    vecs[3] = '{200, 201, 100, 950, 1'b0, 1'b0, 1,   0,  4, 200};
    vecs[4] = '{299, 200, 100, 950, 1'b1, 1'b1, 0,   99, 4, 200};
    vecs[5] = '{200, 300, 150, 950, 1'b0, 1'b0, 100, 0,  3, 300};
    vecs[6] = '{300, 360, 400, 700, 1'b0, 1'b0, 60,  0,  1, 0};

    tick();
    do_reset("reset_init");

    for (int v = 0; v < 7; v++) begin
      do_reset($sformatf("reset_v%0d", v));
      off1 = vecs[v].off1;
      off2 = vecs[v].off2;
      half = vecs[v].half;
      en1 = 1'b1;
      en2 = 1'b1;
      comp_f1 = vecs[v].comp_f1;
      cur_exp = '{fs: vecs[v].fs, d1: vecs[v].d1, d2: vecs[v].d2};
      run_waves(vecs[v].ncyc);
      drain(10);
      check($sformatf("v%0d_ready_count", v), ready_seen, vecs[v].nready);
      check($sformatf("v%0d_pending", v), q.size(), 0);
      check($sformatf("v%0d_f_out", v), int'(f_out), vecs[v].fout);
    end

    // Timeout: one good pair, then f_2 stops, then f_2 resumes 20 cycles behind f_1.
    do_reset("reset_to");
    off1 = 50; off2 = 57; half = 100;
    en1 = 1'b1; en2 = 1'b1; comp_f1 = 1'b0;
    cur_exp = '{fs: 1'b0, d1: 7, d2: 0};
    run_to(100);
    check("to_first_pair_ready", ready_seen, 1);
    en2 = 1'b0;
    run_to(340);
    check("to_before_limit", int'(timeout), 0);
    run_to(370);
    check("to_after_limit", int'(timeout), 1);
    check("to_diff_1_hold", int'(diff_1), 7);
    check("to_diff_2_hold", int'(diff_2), 0);
    check("to_fs_hold", int'(first_second), 0);
    check("to_no_ready", ready_seen, 1);
    run_to(520);
    check("to_sticky", int'(timeout), 1);
    run_to(600);
    off2 = 70;
    en2 = 1'b1;
    cur_exp = '{fs: 1'b0, d1: 20, d2: 0};
    run_to(720);
    check("to_resume_ready", ready_seen, 2);
    check("to_resume_cleared", int'(timeout), 0);
    check("to_resume_diff_1", int'(diff_1), 20);
    drain(5);

    // Reset mid-LEAD1, then a fresh 13-cycle pair.
    do_reset("reset_ml_pre");
    f_1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    f_1 = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    do_reset("reset_mid_lead1");
    for (int i = 0; i < 40; i++) tick();
    check("ml_no_ready", ready_seen, 0);
    check("ml_no_timeout", int'(timeout), 0);
    f_1 = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    q.push_back('{fs: 1'b0, d1: 13, d2: 0});
    f_2 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("ml_pair_ready", ready_seen, 1);
    check("ml_f_out_first_edge", int'(f_out), 0);
    check("ml_pending", q.size(), 0);
    drain(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
